// File: rtl/sysid_ext_slave.sv
// Parametrised system-ID Avalon-MM slave: ID, timestamp, capabilities, clock rate,
// scratch register and optional 64-bit uptime counter (macro SYSID_EXT_UPTIME_EN).
module sysid_ext_slave #(
  parameter logic [31:0] ID_VALUE      = 32'h11223344,
  parameter logic [31:0] TIMESTAMP     = 32'd1459428134,
  parameter int unsigned CLOCK_HZ      = 50000000,
  parameter int unsigned READ_LATENCY  = 1,
  parameter logic [31:0] SCRATCH_RESET = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned AW = 3;

  localparam logic [AW-1:0] ADDR_ID      = AW'(0);
  localparam logic [AW-1:0] ADDR_TS      = AW'(1);
  localparam logic [AW-1:0] ADDR_SCRATCH = AW'(2);
  localparam logic [AW-1:0] ADDR_UP_LO   = AW'(3);
  localparam logic [AW-1:0] ADDR_UP_HI   = AW'(4);
  localparam logic [AW-1:0] ADDR_CAP     = AW'(5);
  localparam logic [AW-1:0] ADDR_CLK     = AW'(6);

`ifdef SYSID_EXT_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif

  localparam logic [DW-1:0] CAP_WORD = {16'h0001, 7'd0, UPTIME_PRESENT, 6'd0, 2'(READ_LATENCY)};

  logic [DW-1:0] scratch;
  logic [DW-1:0] uptime_lo_c;
  logic [DW-1:0] uptime_hi_c;
  logic [DW-1:0] rd_data_c;

  // Scratch register with per-byte write enables
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= SCRATCH_RESET;
    end else if (write && (address == ADDR_SCRATCH)) begin
      for (int i = 0; i < int'(BW); i++) begin
        if (byteenable[i]) scratch[8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

`ifdef SYSID_EXT_UPTIME_EN
  logic [63:0]   uptime;
  logic [DW-1:0] shadow;

  // Free-running counter; a low-word read snapshots the high word for a tear-free pair
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime <= '0;
      shadow <= '0;
    end else begin
      uptime <= uptime + 64'd1;
      if (read && (address == ADDR_UP_LO)) shadow <= uptime[63:32];
    end
  end

  assign uptime_lo_c = uptime[31:0];
  assign uptime_hi_c = shadow;
`else
  assign uptime_lo_c = '0;
  assign uptime_hi_c = '0;
`endif

  // Read mux sampled in the issue cycle
  always_comb begin
    rd_data_c = '0;
    case (address)
      ADDR_ID:      rd_data_c = ID_VALUE;
      ADDR_TS:      rd_data_c = TIMESTAMP;
      ADDR_SCRATCH: rd_data_c = scratch;
      ADDR_UP_LO:   rd_data_c = uptime_lo_c;
      ADDR_UP_HI:   rd_data_c = uptime_hi_c;
      ADDR_CAP:     rd_data_c = CAP_WORD;
      ADDR_CLK:     rd_data_c = DW'(CLOCK_HZ);
      default:      rd_data_c = '0;
    endcase
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          readdata      <= '0;
          readdatavalid <= 1'b0;
        end else begin
          readdatavalid <= read;
          if (read) readdata <= rd_data_c;
        end
      end
    end else if (READ_LATENCY == 2) begin : g_lat2
      logic          s1_valid;
      logic [DW-1:0] s1_data;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          s1_valid      <= 1'b0;
          s1_data       <= '0;
          readdata      <= '0;
          readdatavalid <= 1'b0;
        end else begin
          s1_valid      <= read;
          if (read) s1_data <= rd_data_c;
          readdatavalid <= s1_valid;
          if (s1_valid) readdata <= s1_data;
        end
      end
    end else begin : g_bad_latency
      $error("sysid_ext_slave: READ_LATENCY must be 1 or 2");
    end
  endgenerate

endmodule
